// File: rtl/chimera_pkg.sv
// Shared types and defaults for the cluster clock-gate sequencer.
package chimera_pkg;

    localparam int unsigned ClkGateSettleCycles = 4;
    localparam int unsigned ClkGateIsoTimeout   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISOLATE,
        GATE_WAIT,
        UNGATE_WAIT,
        DEISOLATE
    } chimera_gate_state_e;

endpackage

// File: rtl/chimera_gate_rr_pick.sv
// Combinational round-robin first-one finder: first set bit at or after ptr_i, wrapping.
module chimera_gate_rr_pick #(
    parameter int unsigned N    = 5,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    pending_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    int              pos;
    logic [IdxW-1:0] cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int i = 0; i < int'(N); i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= int'(N)) begin
                pos = pos - int'(N);
            end
            cand = IdxW'(pos);
            if (!valid_o && pending_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/chimera_clu_gate_ctrl.sv
// Serialised, round-robin clock gate / ungate sequencer for the external clusters.
//
// state       | meaning
// IDLE        | no transition running; pick next pending cluster
// ISOLATE     | isolation requested, waiting for ack (abort / timeout possible)
// GATE_WAIT   | isolated, settling before the clock stops; not abortable
// UNGATE_WAIT | clock running again, settling before isolation is released
// DEISOLATE   | isolation released, waiting for the ack to drop
module chimera_clu_gate_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters  = 5,
    parameter int unsigned SettleCycles = ClkGateSettleCycles,
    parameter int unsigned IsoTimeout   = ClkGateIsoTimeout
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumClusters-1:0] gate_req_i,
    input  logic [NumClusters-1:0] dbg_req_i,
    input  logic [NumClusters-1:0] isolated_i,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] gated_o,
    output logic [NumClusters-1:0] err_o,
    output logic                   busy_o
);

    localparam int unsigned CntMax = (SettleCycles > IsoTimeout) ? SettleCycles : IsoTimeout;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = (NumClusters > 1) ? $clog2(NumClusters) : 1;

    chimera_gate_state_e    state_q, state_d;
    logic [IdxW-1:0]        sel_q, sel_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NumClusters-1:0] isolate_q, isolate_d;
    logic [NumClusters-1:0] clk_en_q, clk_en_d;
    logic [NumClusters-1:0] gated_q, gated_d;
    logic [NumClusters-1:0] err_q, err_d;
    logic                   busy_q, busy_d;

    logic [NumClusters-1:0] target;
    logic [NumClusters-1:0] pending;
    logic [IdxW-1:0]        pick_idx;
    logic                   pick_valid;
    logic                   sel_target;
    logic                   sel_ack;
    logic                   iso_expired;
    logic                   settle_done;

    assign target  = gate_req_i & ~dbg_req_i;
    assign pending = (target ^ gated_q) & ~(err_q & target);

    chimera_gate_rr_pick #(
        .N    (NumClusters),
        .IdxW (IdxW)
    ) i_rr_pick (
        .pending_i (pending),
        .ptr_i     (ptr_q),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    assign sel_target  = target[sel_q];
    assign sel_ack     = isolated_i[sel_q];
    assign iso_expired = (cnt_q == CntW'(IsoTimeout - 1));
    // Clock edge and release edge land on the edge where the countdown reaches zero,
    // so a wait state lasts SettleCycles cycles (one cycle minimum when it is 0).
    assign settle_done = (cnt_q <= CntW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            isolate_q <= '0;
            clk_en_q  <= '1;
            gated_q   <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            isolate_q <= isolate_d;
            clk_en_q  <= clk_en_d;
            gated_q   <= gated_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d = pick_idx;
                    ptr_d = (pick_idx == IdxW'(NumClusters - 1)) ? '0 : pick_idx + IdxW'(1);
                    if (gated_q[pick_idx]) begin
                        state_d = UNGATE_WAIT;
                        cnt_d   = CntW'(SettleCycles);
                    end else begin
                        state_d = ISOLATE;
                        cnt_d   = '0;
                    end
                end
            end
            ISOLATE: begin
                if (sel_ack) begin
                    state_d = GATE_WAIT;
                    cnt_d   = CntW'(SettleCycles);
                end else if (!sel_target || iso_expired) begin
                    state_d = DEISOLATE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            GATE_WAIT: begin
                if (settle_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            UNGATE_WAIT: begin
                if (settle_done) begin
                    state_d = DEISOLATE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            DEISOLATE: begin
                if (!sel_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        isolate_d = isolate_q;
        clk_en_d  = clk_en_q;
        gated_d   = gated_q;
        err_d     = err_q & gate_req_i;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (gated_q[pick_idx]) begin
                        clk_en_d[pick_idx] = 1'b1;
                        gated_d[pick_idx]  = 1'b0;
                    end else begin
                        isolate_d[pick_idx] = 1'b1;
                    end
                end
            end
            ISOLATE: begin
                if (!sel_ack && (!sel_target || iso_expired)) begin
                    isolate_d[sel_q] = 1'b0;
                end
                if (!sel_ack && sel_target && iso_expired) begin
                    err_d[sel_q] = 1'b1;
                end
            end
            GATE_WAIT: begin
                if (settle_done) begin
                    clk_en_d[sel_q] = 1'b0;
                    gated_d[sel_q]  = 1'b1;
                end
            end
            UNGATE_WAIT: begin
                if (settle_done) begin
                    isolate_d[sel_q] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign isolate_o = isolate_q;
    assign clk_en_o  = clk_en_q;
    assign gated_o   = gated_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;

endmodule
